// File: rtl/game_pkg.sv
// Shared types and default timing constants for the game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    RESPAWN = 3'd2,
    PAUSED  = 3'd3,
    WON     = 3'd4,
    OVER    = 3'd5
  } game_state_t;

  localparam int DEF_TICK_DIV    = 32'd100_000_000;
  localparam int DEF_LOCKOUT_CYC = 32'd1_000_000;
  localparam int DEF_RESPAWN_CYC = 32'd50_000_000;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Collision/datapath side of the game sequencer: event flags in, commands out.
interface game_sequencer_if;

  logic       coin_det_in;
  logic       outbounds;
  logic       game_win;
  logic       time_zero;
  logic [1:0] lives;

  logic [2:0] state;
  logic       new_game;
  logic       coin_pulse;
  logic       life_lost;
  logic       win_pulse;
  logic       sec_tick;
  logic       freeze;
  logic       respawn;

  modport master (
    output coin_det_in, outbounds, game_win, time_zero, lives,
    input  state, new_game, coin_pulse, life_lost, win_pulse, sec_tick, freeze, respawn
  );

  modport slave (
    input  coin_det_in, outbounds, game_win, time_zero, lives,
    output state, new_game, coin_pulse, life_lost, win_pulse, sec_tick, freeze, respawn
  );

endinterface

// File: rtl/edge_lockout.sv
// Rising-edge event filter: accepts one 0->1 edge, then stays blind for LOCKOUT_CYC cycles.
module edge_lockout
  import game_pkg::*;
#(
  parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  input  logic i_en,
  output logic o_evt
);

  localparam int              CW      = cnt_width(LOCKOUT_CYC);
  localparam logic [CW-1:0]   CNT_MAX = CW'(LOCKOUT_CYC - 1);

  logic          r_prev;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic          r_evt;
  logic          w_accept;

  // Disabled edges neither fire nor arm the lockout.
  assign w_accept = i_sig & ~r_prev & ~r_busy & i_en;
  assign o_evt    = r_evt;

  // Edge register, event register and lockout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_evt  <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_evt  <= w_accept;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_busy) begin
        if (r_cnt == CNT_MAX) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game state controller: button sync, collision filtering, FSM, tick and respawn timers.
// Optional pause feature enabled by defining GAME_SEQ_PAUSE_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
  parameter int RESPAWN_CYC = DEF_RESPAWN_CYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start_btn,
  input  logic            i_pause_btn,
  game_sequencer_if.slave io_gs
);

  localparam int                TICK_W   = cnt_width(TICK_DIV);
  localparam int                RESP_W   = cnt_width(RESPAWN_CYC);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [RESP_W-1:0] RESP_MAX = RESP_W'(RESPAWN_CYC - 1);

  game_state_t       r_state;
  logic              r_start_s1, r_start_s2, r_start_s3, r_start_edge;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [RESP_W-1:0] r_resp_cnt;
  logic              r_new_game, r_coin_pulse, r_life_lost, r_win_pulse, r_sec_tick;
  logic              r_freeze, r_respawn;
  logic              r_win_done, r_win_evt;
  logic              w_play, w_coin_evt, w_oob_evt, w_win_acc, w_pause_edge;

  assign w_play    = (r_state == PLAY);
  assign w_win_acc = io_gs.game_win & ~r_win_done & w_play;

  edge_lockout #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_coin_lock (
    .clk(clk), .rst(rst), .i_sig(io_gs.coin_det_in), .i_en(w_play), .o_evt(w_coin_evt)
  );

  edge_lockout #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_oob_lock (
    .clk(clk), .rst(rst), .i_sig(io_gs.outbounds), .i_en(w_play), .o_evt(w_oob_evt)
  );

  // Start button: two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_s3   <= 1'b0;
      r_start_edge <= 1'b0;
    end else begin
      r_start_s1   <= i_start_btn;
      r_start_s2   <= r_start_s1;
      r_start_s3   <= r_start_s2;
      r_start_edge <= r_start_s2 & ~r_start_s3;
    end
  end

`ifdef GAME_SEQ_PAUSE_EN
  logic r_pause_s1, r_pause_s2, r_pause_s3, r_pause_edge;

  // Pause button: same synchronizer and edge detector as start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pause_s1   <= 1'b0;
      r_pause_s2   <= 1'b0;
      r_pause_s3   <= 1'b0;
      r_pause_edge <= 1'b0;
    end else begin
      r_pause_s1   <= i_pause_btn;
      r_pause_s2   <= r_pause_s1;
      r_pause_s3   <= r_pause_s2;
      r_pause_edge <= r_pause_s2 & ~r_pause_s3;
    end
  end

  assign w_pause_edge = r_pause_edge;
`else
  logic w_unused_pause;
  assign w_unused_pause = i_pause_btn;
  assign w_pause_edge   = 1'b0;
`endif

  // Game FSM with registered command pulses, levels and both timers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_new_game   <= 1'b0;
      r_coin_pulse <= 1'b0;
      r_life_lost  <= 1'b0;
      r_win_pulse  <= 1'b0;
      r_sec_tick   <= 1'b0;
      r_freeze     <= 1'b1;
      r_respawn    <= 1'b0;
      r_tick_cnt   <= '0;
      r_resp_cnt   <= '0;
      r_win_done   <= 1'b0;
      r_win_evt    <= 1'b0;
    end else begin
      r_new_game   <= 1'b0;
      r_coin_pulse <= 1'b0;
      r_life_lost  <= 1'b0;
      r_win_pulse  <= 1'b0;
      r_sec_tick   <= 1'b0;
      r_win_evt    <= w_win_acc;
      if (w_win_acc) begin
        r_win_done <= 1'b1;
      end
      case (r_state)
        IDLE, WON, OVER: begin
          if (r_start_edge) begin
            r_state    <= PLAY;
            r_new_game <= 1'b1;
            r_freeze   <= 1'b0;
            r_tick_cnt <= '0;
            r_win_done <= 1'b0;
          end
        end
        PLAY: begin
          if (r_tick_cnt == TICK_MAX) begin
            r_tick_cnt <= '0;
            r_sec_tick <= 1'b1;
          end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
          // Leaving PLAY swallows a coin arriving in the same cycle.
          if (r_win_evt) begin
            r_state     <= WON;
            r_win_pulse <= 1'b1;
            r_freeze    <= 1'b1;
          end else if (w_oob_evt) begin
            r_life_lost <= 1'b1;
            r_freeze    <= 1'b1;
            if (io_gs.lives > 2'd1) begin
              r_state    <= RESPAWN;
              r_respawn  <= 1'b1;
              r_resp_cnt <= '0;
            end else begin
              r_state <= OVER;
            end
          end else if (io_gs.time_zero) begin
            r_state  <= OVER;
            r_freeze <= 1'b1;
          end else if (w_pause_edge) begin
            r_state  <= PAUSED;
            r_freeze <= 1'b1;
          end else if (w_coin_evt) begin
            r_coin_pulse <= 1'b1;
          end
        end
        RESPAWN: begin
          if (r_resp_cnt == RESP_MAX) begin
            r_state    <= PLAY;
            r_freeze   <= 1'b0;
            r_respawn  <= 1'b0;
            r_resp_cnt <= '0;
          end else begin
            r_resp_cnt <= r_resp_cnt + RESP_W'(1);
          end
        end
        PAUSED: begin
          if (w_pause_edge) begin
            r_state  <= PLAY;
            r_freeze <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_freeze  <= 1'b1;
          r_respawn <= 1'b0;
        end
      endcase
    end
  end

  assign io_gs.state      = r_state;
  assign io_gs.new_game   = r_new_game;
  assign io_gs.coin_pulse = r_coin_pulse;
  assign io_gs.life_lost  = r_life_lost;
  assign io_gs.win_pulse  = r_win_pulse;
  assign io_gs.sec_tick   = r_sec_tick;
  assign io_gs.freeze     = r_freeze;
  assign io_gs.respawn    = r_respawn;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short timing parameters.
module tb_game_sequencer;

  logic clk;
  logic rst;
  logic start_btn;
  logic pause_btn;

  game_sequencer_if gs_if ();

  game_sequencer #(
    .TICK_DIV(10), .LOCKOUT_CYC(4), .RESPAWN_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .i_start_btn(start_btn), .i_pause_btn(pause_btn), .io_gs(gs_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int n_coin = 0, n_life = 0, n_win = 0, n_tick = 0, n_new = 0;
  int coin_last = 0, coin_gap = 0;
  int s_coin, s_life, s_win, s_tick, s_new;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (gs_if.coin_pulse) begin
      n_coin    <= n_coin + 1;
      coin_gap  <= cyc - coin_last;
      coin_last <= cyc;
    end
    if (gs_if.life_lost) n_life <= n_life + 1;
    if (gs_if.win_pulse) n_win <= n_win + 1;
    if (gs_if.sec_tick)  n_tick <= n_tick + 1;
    if (gs_if.new_game)  n_new <= n_new + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic save_counts();
    s_coin = n_coin; s_life = n_life; s_win = n_win; s_tick = n_tick; s_new = n_new;
  endtask

  // Start press: new_game appears 4 cycles after the level is first sampled.
  task automatic press_start(input logic [2:0] from_state);
    start_btn = 1'b1;
    step();
    step();
    start_btn = 1'b0;
    step();
    check_val("start_pre_state", gs_if.state, from_state);
    check_val("start_pre_new", gs_if.new_game, 1'b0);
    step();
    check_val("start_new_game", gs_if.new_game, 1'b1);
    check_val("start_state", gs_if.state, 3'd1);
    check_val("start_freeze", gs_if.freeze, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
    gs_if.coin_det_in = 1'b0; gs_if.outbounds = 1'b0; gs_if.game_win = 1'b0;
    gs_if.time_zero = 1'b0; gs_if.lives = 2'd3;
    repeat (3) step();
    check_val("rst_state", gs_if.state, 3'd0);
    check_val("rst_freeze", gs_if.freeze, 1'b1);
    check_val("rst_respawn", gs_if.respawn, 1'b0);
    check_val("rst_pulses", {gs_if.new_game, gs_if.coin_pulse, gs_if.life_lost,
                             gs_if.win_pulse, gs_if.sec_tick}, 5'd0);
    rst = 1'b1;
    step();
    step();
    check_val("idle_hold", gs_if.state, 3'd0);

    // Game 1, T=0 is the new_game cycle.
    press_start(3'd0);
    step();
    check_val("new_game_width", gs_if.new_game, 1'b0);
    repeat (8) step();
    check_val("tick_t9", gs_if.sec_tick, 1'b0);
    step();
    check_val("tick_t10", gs_if.sec_tick, 1'b1);
    repeat (10) step();
    check_val("tick_t20", gs_if.sec_tick, 1'b1);

    // Coin held 20 cycles -> one pulse, two cycles after first high.
    save_counts();
    gs_if.coin_det_in = 1'b1;
    step();
    check_val("coin_lat1", gs_if.coin_pulse, 1'b0);
    step();
    check_val("coin_lat2", gs_if.coin_pulse, 1'b1);
    repeat (18) step();
    gs_if.coin_det_in = 1'b0;
    check_val("coin_hold_once", n_coin - s_coin, 1);
    step();

    // Coin toggling from T=41: accepted at 41 and 47 only.
    save_counts();
    for (int i = 0; i < 12; i++) begin
      gs_if.coin_det_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    gs_if.coin_det_in = 1'b0;
    repeat (3) step();
    check_val("coin_toggle_cnt", n_coin - s_coin, 2);
    check_val("coin_toggle_gap", coin_gap, 6);

    // T=56: out of bounds with 3 lives -> RESPAWN at T=58, back at T=66, tick at T=68.
    gs_if.outbounds = 1'b1;
    step();
    gs_if.outbounds = 1'b0;
    check_val("oob_lat1", gs_if.life_lost, 1'b0);
    step();
    check_val("oob_life_lost", gs_if.life_lost, 1'b1);
    check_val("oob_state", gs_if.state, 3'd2);
    check_val("oob_respawn", gs_if.respawn, 1'b1);
    check_val("oob_freeze", gs_if.freeze, 1'b1);
    save_counts();
    repeat (7) step();
    check_val("resp_still", gs_if.state, 3'd2);
    check_val("resp_no_tick", n_tick - s_tick, 0);
    step();
    check_val("resp_back", gs_if.state, 3'd1);
    check_val("resp_lvl_off", gs_if.respawn, 1'b0);
    step();
    check_val("phase_t67", gs_if.sec_tick, 1'b0);
    step();
    check_val("phase_t68", gs_if.sec_tick, 1'b1);

    // Last life lost -> OVER.
    gs_if.lives = 2'd1;
    gs_if.outbounds = 1'b1;
    step();
    gs_if.outbounds = 1'b0;
    step();
    check_val("last_life_lost", gs_if.life_lost, 1'b1);
    check_val("last_life_state", gs_if.state, 3'd5);
    check_val("last_life_freeze", gs_if.freeze, 1'b1);
    gs_if.lives = 2'd3;
    step();

    // Simultaneous win/outbounds/coin -> only win.
    press_start(3'd5);
    save_counts();
    gs_if.game_win = 1'b1; gs_if.outbounds = 1'b1; gs_if.coin_det_in = 1'b1;
    step();
    gs_if.outbounds = 1'b0; gs_if.coin_det_in = 1'b0;
    step();
    check_val("win_pulse", gs_if.win_pulse, 1'b1);
    check_val("win_state", gs_if.state, 3'd4);
    gs_if.game_win = 1'b0;
    repeat (3) step();
    check_val("win_only_coin", n_coin - s_coin, 0);
    check_val("win_only_life", n_life - s_life, 0);
    check_val("win_once", n_win - s_win, 1);

    // Second game: win accepted once more.
    press_start(3'd4);
    save_counts();
    gs_if.game_win = 1'b1;
    repeat (5) step();
    gs_if.game_win = 1'b0;
    check_val("win2_count", n_win - s_win, 1);
    check_val("win2_state", gs_if.state, 3'd4);

    // time_zero -> OVER.
    press_start(3'd4);
    gs_if.time_zero = 1'b1;
    step();
    gs_if.time_zero = 1'b0;
    check_val("tz_state", gs_if.state, 3'd5);
    check_val("tz_freeze", gs_if.freeze, 1'b1);
    step();
    press_start(3'd5);

    // Pause handling from the new_game cycle.
    pause_btn = 1'b1;
    step();
    step();
    pause_btn = 1'b0;
    step();
    check_val("pause_pre", gs_if.state, 3'd1);
    step();
`ifdef GAME_SEQ_PAUSE_EN
    check_val("pause_enter", gs_if.state, 3'd3);
    check_val("pause_freeze", gs_if.freeze, 1'b1);
`else
    check_val("pause_ignored", gs_if.state, 3'd1);
`endif
    save_counts();
    for (int i = 0; i < 30; i++) begin
      gs_if.coin_det_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    gs_if.coin_det_in = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
    check_val("pause_no_coin", n_coin - s_coin, 0);
    check_val("pause_no_tick", n_tick - s_tick, 0);
`else
    check_val("nopause_coins", n_coin - s_coin, 5);
    check_val("nopause_ticks", n_tick - s_tick, 3);
`endif
    pause_btn = 1'b1;
    step();
    step();
    pause_btn = 1'b0;
    step();
`ifdef GAME_SEQ_PAUSE_EN
    check_val("resume_pre", gs_if.state, 3'd3);
`else
    check_val("resume_pre", gs_if.state, 3'd1);
`endif
    step();
    check_val("resume_state", gs_if.state, 3'd1);
    repeat (6) step();
`ifdef GAME_SEQ_PAUSE_EN
    check_val("resume_tick", gs_if.sec_tick, 1'b1);
`endif

    // Reset during RESPAWN.
    gs_if.outbounds = 1'b1;
    step();
    gs_if.outbounds = 1'b0;
    step();
    check_val("rst2_respawn", gs_if.state, 3'd2);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_val("rst2_async_state", gs_if.state, 3'd0);
    check_val("rst2_freeze", gs_if.freeze, 1'b1);
    check_val("rst2_respawn_lvl", gs_if.respawn, 1'b0);
    step();
    rst = 1'b1;
    save_counts();
    repeat (20) step();
    check_val("rst2_quiet", (n_coin - s_coin) + (n_life - s_life) + (n_win - s_win)
                            + (n_tick - s_tick) + (n_new - s_new), 0);
    check_val("rst2_idle", gs_if.state, 3'd0);
    press_start(3'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
